// File: rtl/shift_rx.sv
// shift_rx: drives an external 74299-style chain to parallel-load a word, then shifts it out Q0-first and reassembles it LSB-first.
module shift_rx #(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             START,
  output logic             BUSY,
  output logic [1:0]       S,
  output logic             CE,
  output logic             DSR,
  input  logic             SIN,
  output logic [WIDTH-1:0] DATA,
  output logic             VALID,
  input  logic             READY
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] asm_q;
  logic             free;
  assign DSR  = 1'b0;
  assign free = !VALID || READY;
  // S, CE and BUSY are registered alongside the state so they always reflect the state being entered.
  always_ff @(posedge CP) begin
    if (MR) begin
      state <= IDLE;
      cnt   <= '0;
      asm_q <= '0;
      DATA  <= '0;
      VALID <= 1'b0;
      BUSY  <= 1'b0;
      S     <= 2'b00;
      CE    <= 1'b0;
    end else begin
      if (VALID && READY) VALID <= 1'b0;
      case (state)
        IDLE: if (START) begin
          state <= LOAD;
          BUSY  <= 1'b1;
          S     <= 2'b11;
          CE    <= 1'b1;
        end
        LOAD: begin
          cnt   <= '0;
          state <= SHIFT;
          S     <= 2'b10;
        end
        SHIFT: begin
          asm_q[cnt] <= SIN;
          cnt        <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            S     <= 2'b00;
            CE    <= 1'b0;
          end
        end
        DONE: if (free) begin
          DATA  <= asm_q;
          VALID <= 1'b1;
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_shift_rx.sv
// tb_shift_rx: random and directed checks of shift_rx against a transaction-level model, with a 74299-like chain as the environment.
module tb_shift_rx;
  localparam int W = 8;
  localparam int W2 = 16;
  logic CP = 1'b0;
  always #5 CP = ~CP;
  logic MR, START, READY, BUSY, CE, DSR, SIN, VALID;
  logic [1:0] S;
  logic [W-1:0] DATA, par, chain;
  logic MR2, START2, READY2, BUSY2, CE2, DSR2, SIN2, VALID2;
  logic [1:0] S2;
  logic [W2-1:0] DATA2, par2, chain2;
  shift_rx #(.WIDTH(W)) dut (.CP(CP), .MR(MR), .START(START), .BUSY(BUSY), .S(S), .CE(CE),
    .DSR(DSR), .SIN(SIN), .DATA(DATA), .VALID(VALID), .READY(READY));
  shift_rx #(.WIDTH(W2)) dut16 (.CP(CP), .MR(MR2), .START(START2), .BUSY(BUSY2), .S(S2), .CE(CE2),
    .DSR(DSR2), .SIN(SIN2), .DATA(DATA2), .VALID(VALID2), .READY(READY2));
  always @(posedge CP) begin
    if (CE) chain <= (S == 2'b11) ? par : (S == 2'b10) ? {DSR, chain[W-1:1]} : chain;
    if (CE2) chain2 <= (S2 == 2'b11) ? par2 : (S2 == 2'b10) ? {DSR2, chain2[W2-1:1]} : chain2;
  end
  assign SIN  = chain[0];
  assign SIN2 = chain2[0];
  int passed = 0, total = 0;
  int ph = 0;
  logic [W-1:0] word_m = '0, data_m = '0;
  logic valid_m = 1'b0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // ph counts cycles since START was accepted: 1 load, 2..W+1 shift, W+2 waiting to deliver.
  task automatic model(input logic mr, input logic st, input logic rd);
    logic nv;
    if (mr) begin
      ph = 0; data_m = '0; valid_m = 1'b0;
    end else begin
      nv = valid_m && !rd;
      if (ph == 0) ph = st ? 1 : 0;
      else if (ph == 1) begin word_m = par; ph = 2; end
      else if (ph <= W + 1) ph = ph + 1;
      else if (!valid_m || rd) begin data_m = word_m; nv = 1'b1; ph = 0; end
      valid_m = nv;
    end
  endtask
  task automatic compare_all();
    chk("S", S, ph == 1 ? 3 : (ph >= 2 && ph <= W + 1) ? 2 : 0);
    chk("CE", CE, ph >= 1 && ph <= W + 1);
    chk("BUSY", BUSY, ph != 0);
    chk("DSR", DSR, 0);
    chk("VALID", VALID, valid_m);
    chk("DATA", DATA, data_m);
  endtask
  task automatic step(input logic mr, input logic st, input logic rd);
    MR = mr; START = st; READY = rd;
    model(mr, st, rd);
    @(negedge CP);
    compare_all();
  endtask
  initial begin
    int nw, last;
    MR2 = 1'b1; START2 = 1'b0; READY2 = 1'b1; par2 = 16'h8001;
    par = '0;
    step(1, 0, 1); step(1, 0, 1);
    chk("rst_busy", BUSY, 0); chk("rst_valid", VALID, 0); chk("rst_data", DATA, 0);
    chk("rst_s", S, 0); chk("rst_ce", CE, 0);
    par = 8'hA5;
    step(0, 1, 1);
    chk("a5_s_load", S, 2'b11);
    for (int c = 2; c <= 9; c++) begin step(0, 0, 1); chk("a5_s_shift", S, 2'b10); end
    step(0, 0, 1); chk("a5_done_busy", BUSY, 1);
    step(0, 0, 1);
    chk("a5_valid11", VALID, 1); chk("a5_data11", DATA, 8'hA5); chk("a5_model", data_m, 8'hA5);
    chk("a5_busy11", BUSY, 0);
    step(0, 0, 1); chk("a5_valid12", VALID, 0);
    par = 8'h3C;
    step(0, 1, 0);
    for (int c = 0; c < W + 2; c++) step(0, 0, 0);
    chk("bp_first", DATA, 8'h3C); chk("bp_valid", VALID, 1);
    par = 8'hC3;
    step(0, 1, 0);
    for (int c = 0; c < W + 4; c++) step(0, 0, 0);
    chk("bp_hold", DATA, 8'h3C); chk("bp_wait_busy", BUSY, 1);
    step(0, 0, 1);
    chk("bp_next", DATA, 8'hC3); chk("bp_valid_stays", VALID, 1); chk("bp_model", data_m, 8'hC3);
    step(0, 0, 1); chk("bp_drain", VALID, 0);
    par = 8'h5A; nw = 0;
    step(0, 1, 1);
    for (int c = 1; c <= W + 6; c++) begin
      step(0, c == 3 || c == 7, 1);
      if (VALID) nw++;
    end
    chk("ign_words", nw, 1); chk("ign_data", DATA, 8'h5A);
    par = 8'h66;
    step(0, 1, 1);
    for (int c = 1; c < 5; c++) step(0, 0, 1);
    step(1, 0, 1);
    chk("mr_s", S, 0); chk("mr_ce", CE, 0); chk("mr_busy", BUSY, 0);
    chk("mr_valid", VALID, 0); chk("mr_data", DATA, 0);
    par = 8'hFF;
    step(0, 1, 1);
    for (int c = 0; c < W + 2; c++) step(0, 0, 1);
    chk("mr_restart_valid", VALID, 1); chk("mr_restart_data", DATA, 8'hFF);
    for (int c = 0; c < 3000; c++) begin
      par = W'($urandom);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    @(negedge CP); @(negedge CP);
    MR2 = 1'b0; START2 = 1'b1; nw = 0; last = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CP);
      chk("w16_valid", VALID2, c % 19 == 0);
      if (VALID2) begin
        chk("w16_data", DATA2, 16'h8001);
        if (last != 0) chk("w16_spacing", c - last, 19);
        last = c; nw++;
      end
    end
    chk("w16_words", nw, 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_rx.md
SHIFT_RX -- requirements
Module: shift_rx

Interface
REQ-001 Parameter WIDTH, default 8, SHALL be the number of bits captured per word (the chain length: 8 per 74299 package); legal values 8, 16, 24, 32.
REQ-002 Port CP  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port MR  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 Port START  input  1  SHALL request one capture-and-deserialize operation.
REQ-005 Port BUSY  output  1  SHALL be high whenever the state machine is not in IDLE.
REQ-006 Port S  output  2  SHALL be the mode select to the external chain: 00 hold, 11 parallel load, 10 shift toward Q0.
REQ-007 Port CE  output  1  SHALL be the chain clock enable; the chain advances on a CP edge only when CE=1.
REQ-008 Port DSR  output  1  SHALL be the serial fill bit into the chain MSB, constant 0.
REQ-009 Port SIN  input  1  SHALL be the serial bit from the chain Q0 output.
REQ-010 Port DATA  output  WIDTH  SHALL be the assembled word.
REQ-011 Port VALID  output  1  SHALL indicate that DATA holds an unconsumed word.
REQ-012 Port READY  input  1  SHALL indicate that the consumer accepts DATA on this edge.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SHIFT and DONE; there is one state register and one bit counter of ceil(log2(WIDTH)) bits.
REQ-014 IDLE: outputs S=00, CE=0; START=1 -> LOAD; START in any other state SHALL be ignored, with no queuing.
REQ-015 LOAD (exactly 1 cycle): outputs S=11, CE=1, so the chain captures its parallel inputs; counter<=0; next state SHIFT.
REQ-016 SHIFT (exactly WIDTH cycles): outputs S=10, CE=1; each edge stores asm[counter]<=SIN and increments counter; at counter==WIDTH-1, next state DONE.
REQ-017 Bit order: the first SIN sample SHALL land in bit 0 (LSB), the last in bit WIDTH-1, so DATA equals the word the chain loaded.
REQ-018 DONE: outputs S=00, CE=0; the output is free when VALID==0 or READY==1.
  - Free: DATA<=asm, VALID<=1, next state IDLE.
  - Not free: remain in DONE; DATA is unchanged.
REQ-019 Handshake: VALID&&READY at an edge SHALL consume the word; VALID then falls the next cycle unless DONE loads a new word on the same edge, in which case VALID stays 1 and DATA changes.
REQ-020 DATA SHALL hold stable while VALID=1 and READY=0.
REQ-021 Latency: START sampled at edge 0 -> LOAD in cycle 1 -> SHIFT in cycles 2..WIDTH+1 -> DONE in cycle WIDTH+2.
  - With the output free, VALID=1 and BUSY=0 SHALL occur in cycle WIDTH+3 (cycle 11 for WIDTH=8).
REQ-022 Back-to-back: START held high continuously SHALL produce one word per WIDTH+3 cycles when READY=1.
REQ-023 The assembly register SHALL be internal; partial words SHALL never appear on DATA.

Reset
REQ-024 MR=1 at an edge SHALL force the following, overriding every other input, including an in-progress LOAD, SHIFT or DONE:
  - state IDLE, counter 0
  - S=00, CE=0, DSR=0
  - DATA=0, VALID=0, BUSY=0
REQ-025 A reset mid-operation SHALL discard the partial word; the next operation restarts from LOAD.

Verification
REQ-026 WIDTH=8, chain model parallel inputs 0xA5, READY=1, START pulse at cycle 0 -> S=11 in cycle 1, S=10 in cycles 2..9, VALID=1 with DATA=0xA5 in cycle 11, VALID=0 in cycle 12.
REQ-027 Backpressure: READY=0, capture 0x3C then START again with inputs 0xC3 -> DATA holds 0x3C, FSM waits in DONE with BUSY=1; READY=1 for one edge -> DATA=0xC3, VALID stays 1.
REQ-028 START pulsed in cycles 3 and 7 of an active operation -> ignored; exactly one word is produced.
REQ-029 MR=1 in cycle 5 (mid-SHIFT) -> next cycle S=00, CE=0, BUSY=0, VALID=0, DATA=0; a fresh START with 0xFF -> DATA=0xFF after WIDTH+3 cycles.
REQ-030 WIDTH=16, chain inputs 0x8001, continuous START, READY=1 -> successive words 0x8001 at 19-cycle spacing, with the LSB/MSB order confirmed.
